// File: rtl/snn_syn_pkg.sv
// Shared types and constants for the synaptic SRAM read-modify-write controller.
// SYN_WEIGHT_SIGNED_EN selects two's complement weight clamp bounds.
package snn_syn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_CALC = 2'd2,
      ST_WR   = 2'd3
   } state_t;

   localparam logic OP_READ   = 1'b0;
   localparam logic OP_UPDATE = 1'b1;

   function automatic int clamp_lo(input int w);
`ifdef SYN_WEIGHT_SIGNED_EN
      return -(32'sd1 <<< (w - 32'sd1));
`else
      return 32'sd0;
`endif
   endfunction

   function automatic int clamp_hi(input int w);
`ifdef SYN_WEIGHT_SIGNED_EN
      return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
`else
      return (32'sd1 <<< w) - 32'sd1;
`endif
   endfunction

endpackage

// File: rtl/syn_sat_add.sv
// Extracts one weight lane, adds a signed increment and saturates the result.
// SYN_WEIGHT_SIGNED_EN treats the lane as two's complement.
module syn_sat_add
   import snn_syn_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int W_BITS     = 4,
   parameter int IDX_WIDTH  = 3
) (
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [IDX_WIDTH-1:0]  idx_i,
   input  logic [W_BITS:0]       delta_i,
   output logic [W_BITS-1:0]     field_o
);

   localparam int LO = clamp_lo(W_BITS);
   localparam int HI = clamp_hi(W_BITS);

   logic [W_BITS-1:0]        field_s;
   logic signed [W_BITS+1:0] field_ext_s;
   logic signed [W_BITS+1:0] delta_ext_s;
   logic signed [W_BITS+1:0] sum_s;

   // Two guard bits keep the widest sum from overflowing before the clamp.
   always_comb begin
      field_s = word_i[idx_i*W_BITS +: W_BITS];
`ifdef SYN_WEIGHT_SIGNED_EN
      field_ext_s = {{2{field_s[W_BITS-1]}}, field_s};
`else
      field_ext_s = {2'b00, field_s};
`endif
      delta_ext_s = {delta_i[W_BITS], delta_i};
      sum_s       = field_ext_s + delta_ext_s;
      if (int'(sum_s) < LO) begin
         field_o = LO[W_BITS-1:0];
      end else if (int'(sum_s) > HI) begin
         field_o = HI[W_BITS-1:0];
      end else begin
         field_o = sum_s[W_BITS-1:0];
      end
   end

endmodule

// File: rtl/syn_sram_rmw_ctrl.sv
// Serialises word reads and saturating per-synapse read-modify-write updates
// onto one synaptic SRAM port. SYN_WEIGHT_SIGNED_EN selects signed weights.
module syn_sram_rmw_ctrl
   import snn_syn_pkg::*;
#(
   parameter  int ADDR_WIDTH   = 8,
   parameter  int DATA_WIDTH   = 32,
   parameter  int W_BITS       = 4,
   localparam int SYN_PER_WORD = DATA_WIDTH / W_BITS,
   localparam int IDX_WIDTH    = $clog2(SYN_PER_WORD)
) (
   input  logic                  CK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic                  REQ_OP,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [IDX_WIDTH-1:0]  REQ_IDX,
   input  logic [W_BITS:0]       REQ_DELTA,
   output logic                  RSP_VALID,
   output logic [DATA_WIDTH-1:0] RSP_DATA,
   output logic                  SRAM_CS,
   output logic                  SRAM_WE,
   output logic [ADDR_WIDTH-1:0] SRAM_A,
   output logic [DATA_WIDTH-1:0] SRAM_D,
   input  logic [DATA_WIDTH-1:0] SRAM_Q
);

   state_t                state_q, state_d;
   logic                  op_q, op_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [W_BITS:0]       delta_q, delta_d;
   logic [ADDR_WIDTH-1:0] a_q, a_d;
   logic                  cs_q, cs_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] d_q, d_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [W_BITS-1:0]     new_field_s;
   logic [DATA_WIDTH-1:0] merged_s;

   syn_sat_add #(
      .DATA_WIDTH (DATA_WIDTH),
      .W_BITS     (W_BITS),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_sat_add (
      .word_i  (SRAM_Q),
      .idx_i   (idx_q),
      .delta_i (delta_q),
      .field_o (new_field_s)
   );

   // Next-state and registered-output decode; strobes default low each cycle.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      idx_d       = idx_q;
      delta_d     = delta_q;
      a_d         = a_q;
      cs_d        = 1'b0;
      we_d        = 1'b0;
      d_d         = d_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      merged_s    = SRAM_Q;
      merged_s[idx_q*W_BITS +: W_BITS] = new_field_s;
      case (state_q)
         ST_IDLE: begin
            if (REQ_VALID) begin
               op_d    = REQ_OP;
               idx_d   = REQ_IDX;
               delta_d = REQ_DELTA;
               a_d     = REQ_ADDR;
               cs_d    = 1'b1;
               state_d = ST_RD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            state_d = ST_CALC;
         end
         ST_CALC: begin
            if (op_q == OP_READ) begin
               rsp_data_d  = SRAM_Q;
               rsp_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               d_d     = merged_s;
               cs_d    = 1'b1;
               we_d    = 1'b1;
               state_d = ST_WR;
            end
         end
         ST_WR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_READ;
         idx_q       <= '0;
         delta_q     <= '0;
         a_q         <= '0;
         cs_q        <= 1'b0;
         we_q        <= 1'b0;
         d_q         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         delta_q     <= delta_d;
         a_q         <= a_d;
         cs_q        <= cs_d;
         we_q        <= we_d;
         d_q         <= d_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign REQ_READY = (state_q == ST_IDLE) & ~RST;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_DATA  = rsp_data_q;
   assign SRAM_CS   = cs_q;
   assign SRAM_WE   = we_q;
   assign SRAM_A    = a_q;
   assign SRAM_D    = d_q;

endmodule

// File: tb/tb_syn_sram_rmw_ctrl.sv
// Bench for syn_sram_rmw_ctrl: SRAM model, directed cases, then random traffic
// against an array-based reference memory.
module tb_syn_sram_rmw_ctrl;

   logic        CK = 1'b0;
   logic        RST;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_OP;
   logic [7:0]  REQ_ADDR;
   logic [2:0]  REQ_IDX;
   logic [4:0]  REQ_DELTA;
   logic        RSP_VALID;
   logic [31:0] RSP_DATA;
   logic        SRAM_CS;
   logic        SRAM_WE;
   logic [7:0]  SRAM_A;
   logic [31:0] SRAM_D;
   logic [31:0] SRAM_Q;

   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];
   logic        init_req;
   int          total_cnt = 0;
   int          pass_cnt  = 0;
   int          fail_cnt  = 0;

   syn_sram_rmw_ctrl dut (
      .CK        (CK),
      .RST       (RST),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_OP    (REQ_OP),
      .REQ_ADDR  (REQ_ADDR),
      .REQ_IDX   (REQ_IDX),
      .REQ_DELTA (REQ_DELTA),
      .RSP_VALID (RSP_VALID),
      .RSP_DATA  (RSP_DATA),
      .SRAM_CS   (SRAM_CS),
      .SRAM_WE   (SRAM_WE),
      .SRAM_A    (SRAM_A),
      .SRAM_D    (SRAM_D),
      .SRAM_Q    (SRAM_Q)
   );

   always #5 CK = ~CK;

   // Synchronous SRAM: registered read, Q holds while CS is low.
   always @(posedge CK) begin
      if (init_req) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[3] <= 32'h76543210;
         mem[4] <= 32'h76543210;
         SRAM_Q <= 32'h0;
      end else if (SRAM_CS) begin
         if (SRAM_WE) mem[SRAM_A] <= SRAM_D;
         else         SRAM_Q      <= mem[SRAM_A];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   function automatic logic [31:0] model_upd(input logic [31:0] w, input int idx, input logic [4:0] dl);
      int f, d, s, lo, hi;
      f = int'((w >> (idx * 4)) & 32'hF);
      d = int'($signed(dl));
`ifdef SYN_WEIGHT_SIGNED_EN
      if (f > 7) f = f - 16;
      lo = -8;
      hi = 7;
`else
      lo = 0;
      hi = 15;
`endif
      s = f + d;
      if (s < lo) s = lo;
      if (s > hi) s = hi;
      return (w & ~(32'hF << (idx * 4))) | ((32'(s) & 32'hF) << (idx * 4));
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!REQ_READY && n < 20) begin
         tick();
         n++;
      end
      check("ready_timeout", 32'(REQ_READY), 32'd1);
   endtask

   task automatic do_read(input logic [7:0] a, input logic [31:0] exp);
      wait_ready();
      REQ_VALID = 1'b1;
      REQ_OP    = 1'b0;
      REQ_ADDR  = a;
      REQ_IDX   = 3'($urandom);
      REQ_DELTA = 5'($urandom);
      tick();
      REQ_VALID = 1'b0;
      REQ_ADDR  = 8'($urandom);
      check("rd_e0_cs",  32'(SRAM_CS),   32'd1);
      check("rd_e0_we",  32'(SRAM_WE),   32'd0);
      check("rd_e0_a",   32'(SRAM_A),    32'(a));
      check("rd_e0_rdy", 32'(REQ_READY), 32'd0);
      tick();
      check("rd_e1_cs",  32'(SRAM_CS),   32'd0);
      check("rd_e1_we",  32'(SRAM_WE),   32'd0);
      check("rd_e1_rsp", 32'(RSP_VALID), 32'd0);
      tick();
      check("rd_e2_rsp",  32'(RSP_VALID), 32'd1);
      check("rd_e2_data", RSP_DATA,       exp);
      check("rd_e2_we",   32'(SRAM_WE),   32'd0);
      check("rd_e2_cs",   32'(SRAM_CS),   32'd0);
      tick();
      check("rd_e3_rsp",  32'(RSP_VALID), 32'd0);
      check("rd_e3_hold", RSP_DATA,       exp);
      check("rd_e3_rdy",  32'(REQ_READY), 32'd1);
   endtask

   task automatic do_update(input logic [7:0] a, input logic [2:0] idx, input logic [4:0] dl);
      logic [31:0] exp;
      exp        = model_upd(ref_mem[a], int'(idx), dl);
      ref_mem[a] = exp;
      wait_ready();
      REQ_VALID = 1'b1;
      REQ_OP    = 1'b1;
      REQ_ADDR  = a;
      REQ_IDX   = idx;
      REQ_DELTA = dl;
      tick();
      REQ_VALID = 1'b0;
      REQ_ADDR  = 8'($urandom);
      REQ_IDX   = 3'($urandom);
      REQ_DELTA = 5'($urandom);
      check("up_e0_cs",  32'(SRAM_CS),   32'd1);
      check("up_e0_we",  32'(SRAM_WE),   32'd0);
      check("up_e0_rdy", 32'(REQ_READY), 32'd0);
      tick();
      check("up_e1_cs",  32'(SRAM_CS),   32'd0);
      check("up_e1_we",  32'(SRAM_WE),   32'd0);
      check("up_e1_rdy", 32'(REQ_READY), 32'd0);
      tick();
      check("up_e2_cs",  32'(SRAM_CS),   32'd1);
      check("up_e2_we",  32'(SRAM_WE),   32'd1);
      check("up_e2_a",   32'(SRAM_A),    32'(a));
      check("up_e2_d",   SRAM_D,         exp);
      check("up_e2_rsp", 32'(RSP_VALID), 32'd0);
      check("up_e2_rdy", 32'(REQ_READY), 32'd0);
      tick();
      check("up_e3_we",  32'(SRAM_WE),   32'd0);
      check("up_e3_cs",  32'(SRAM_CS),   32'd0);
      check("up_e3_rdy", 32'(REQ_READY), 32'd1);
      check("up_e3_mem", mem[a],         exp);
   endtask

   initial begin
      logic [7:0]  ra;
      logic [2:0]  ri;
      logic [4:0]  rd;
      logic [31:0] saved;
      RST       = 1'b1;
      init_req  = 1'b1;
      REQ_VALID = 1'b0;
      REQ_OP    = 1'b0;
      REQ_ADDR  = 8'h0;
      REQ_IDX   = 3'h0;
      REQ_DELTA = 5'h0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      ref_mem[3] = 32'h76543210;
      ref_mem[4] = 32'h76543210;
      tick();
      init_req = 1'b0;
      tick();
      check("rst_rdy_low", 32'(REQ_READY), 32'd0);
      check("rst_cs",      32'(SRAM_CS),   32'd0);
      RST = 1'b0;
      #1;
      check("rst_rdy",   32'(REQ_READY), 32'd1);
      check("rst_we",    32'(SRAM_WE),   32'd0);
      check("rst_a",     32'(SRAM_A),    32'd0);
      check("rst_d",     SRAM_D,         32'd0);
      check("rst_rsp",   32'(RSP_VALID), 32'd0);
      check("rst_rdata", RSP_DATA,       32'd0);

      do_read(8'd3, 32'h76543210);
`ifndef SYN_WEIGHT_SIGNED_EN
      do_update(8'd3, 3'd2, 5'd5);
      do_read(8'd3, 32'h76543710);
      do_update(8'd4, 3'd7, 5'd15);
      do_read(8'd4, 32'hF6543210);
      do_update(8'd4, 3'd0, 5'h18);
      do_update(8'd4, 3'd1, 5'h18);
      do_read(8'd4, 32'hF6543200);
`else
      do_update(8'd9, 3'd0, 5'd7);
      do_update(8'd9, 3'd0, 5'd3);
      do_update(8'd9, 3'd1, 5'h18);
      do_update(8'd9, 3'd1, 5'h1F);
      do_read(8'd9, 32'h00000087);
`endif
      do_update(8'd3, 3'd5, 5'd0);
      do_read(8'd3, ref_mem[3]);
      do_update(8'd5, 3'd1, 5'd1);
      do_read(8'd5, 32'h00000010);

      // Reset landing in the CALC cycle of an update must suppress the write.
      saved = ref_mem[3];
      wait_ready();
      REQ_VALID = 1'b1;
      REQ_OP    = 1'b1;
      REQ_ADDR  = 8'd3;
      REQ_IDX   = 3'd0;
      REQ_DELTA = 5'd4;
      tick();
      REQ_VALID = 1'b0;
      tick();
      RST = 1'b1;
      tick();
      check("abort_we",  32'(SRAM_WE), 32'd0);
      check("abort_cs",  32'(SRAM_CS), 32'd0);
      RST = 1'b0;
      #1;
      check("abort_rdy",   32'(REQ_READY), 32'd1);
      check("abort_rsp",   32'(RSP_VALID), 32'd0);
      check("abort_a",     32'(SRAM_A),    32'd0);
      check("abort_d",     SRAM_D,         32'd0);
      check("abort_rdata", RSP_DATA,       32'd0);
      tick();
      check("abort_we2", 32'(SRAM_WE), 32'd0);
      check("abort_mem", mem[3],       saved);
      do_read(8'd3, saved);

      for (int n = 0; n < 60; n++) begin
         ra = 8'($urandom_range(0, 7));
         ri = 3'($urandom);
         rd = 5'($urandom);
         if ($urandom_range(0, 1) == 0) do_read(ra, ref_mem[ra]);
         else                          do_update(ra, ri, rd);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
